// File: rtl/cube_pkg.sv
// Shared constants for the cube block: state encodings and datapath widths.
// The cbrt block uses the same package when it shares the external adder.
package cube_pkg;

    localparam int unsigned XW = 4;   // operand width
    localparam int unsigned SW = 8;   // square width
    localparam int unsigned RW = 12;  // result width
    localparam int unsigned AW = 16;  // external adder width

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSq   = 2'd1;
    localparam logic [1:0] StCu   = 2'd2;

    localparam logic [1:0] LastStep = 2'd3;

endpackage

// File: rtl/cube.sv
// Unsigned 4-bit cube, computed as two 4-step shift-and-add multiplies.
// Every addition goes through an external, possibly shared, 16-bit adder.
module cube
    import cube_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [XW-1:0] x,
    input  logic          start,
    output logic [RW-1:0] res,
    output logic          busy,
    output logic [AW-1:0] adder_a_in,
    output logic [AW-1:0] adder_b_in,
    input  logic [AW-1:0] adder_s_out
);

    logic [1:0]    state_q, state_d;
    logic [1:0]    step_q, step_d;
    logic [XW-1:0] x_q, x_d;
    logic [RW-1:0] acc_q, acc_d;
    logic [SW-1:0] sq_q, sq_d;
    logic [RW-1:0] res_q, res_d;
    logic          busy_q, busy_d;

    // Sums never exceed 12 bits, so the adder's top nibble is dropped.
    logic unused_sum_hi;
    assign unused_sum_hi = ^adder_s_out[AW-1:RW];

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        x_d        = x_q;
        acc_d      = acc_q;
        sq_d       = sq_q;
        res_d      = res_q;
        busy_d     = busy_q;
        adder_a_in = '0;
        adder_b_in = '0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    x_d     = x;
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = StSq;
                    busy_d  = 1'b1;
                end
            end

            StSq: begin
                adder_a_in = AW'(acc_q[SW-1:0]);
                adder_b_in = x_q[step_q] ? (AW'(x_q) << step_q) : '0;
                acc_d      = RW'(adder_s_out[SW-1:0]);
                step_d     = step_q + 2'd1;
                if (step_q == LastStep) begin
                    sq_d    = adder_s_out[SW-1:0];
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = StCu;
                end
            end

            StCu: begin
                adder_a_in = AW'(acc_q);
                adder_b_in = x_q[step_q] ? (AW'(sq_q) << step_q) : '0;
                acc_d      = adder_s_out[RW-1:0];
                step_d     = step_q + 2'd1;
                if (step_q == LastStep) begin
                    res_d   = adder_s_out[RW-1:0];
                    busy_d  = 1'b0;
                    step_d  = '0;
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                step_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            step_q  <= '0;
            x_q     <= '0;
            acc_q   <= '0;
            sq_q    <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            sq_q    <= sq_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
        end
    end

    assign res  = res_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_cube.sv
// Directed bench for cube: exhaustive operands, start-while-busy, reset abort,
// back-to-back operations and idle adder inputs. The adder is modelled here.
module tb_cube;

    logic        clk;
    logic        rst;
    logic [3:0]  x;
    logic        start;
    logic [11:0] res;
    logic        busy;
    logic [15:0] adder_a_in;
    logic [15:0] adder_b_in;
    logic [15:0] adder_s_out;

    int          n_cmp;
    int          n_bad;
    logic [11:0] last_res;

    assign adder_s_out = adder_a_in + adder_b_in;

    cube dut (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .start       (start),
        .res         (res),
        .busy        (busy),
        .adder_a_in  (adder_a_in),
        .adder_b_in  (adder_b_in),
        .adder_s_out (adder_s_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge with busy=0; returns at the negedge where busy first reads 0.
    // mode 1 pulses start with x=9 on busy cycle 3, which must be ignored.
    task automatic run_op(input logic [3:0] xv, input int mode);
        int          cnt;
        logic [11:0] expv;
        expv  = 12'(xv) * 12'(xv) * 12'(xv);
        x     = xv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x     = ~xv;
        check("busy_rise", {31'd0, busy}, 32'd1);
        check("res_hold", {20'd0, res}, {20'd0, last_res});
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            if (mode == 1 && cnt == 3) begin
                x     = 4'd9;
                start = 1'b1;
            end
            if (mode == 1 && cnt == 4) start = 1'b0;
            @(negedge clk);
        end
        check("busy_len", cnt, 32'd8);
        check("res", {20'd0, res}, {20'd0, expv});
        last_res = expv;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        last_res = '0;
        rst      = 1'b0;
        x        = 4'd0;
        start    = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_res", {20'd0, res}, 32'd0);
        check("rst_adder", {adder_a_in, adder_b_in}, 32'd0);

        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // No start: adder inputs must sit at zero.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_adder", {adder_a_in, adder_b_in}, 32'd0);
        end
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Exhaustive, issued back to back.
        for (int i = 0; i < 16; i++) run_op(4'(i), 0);

        // Explicit spot values.
        run_op(4'd3, 0);
        check("x3_is_27", {20'd0, res}, 32'd27);
        run_op(4'd15, 0);
        check("x15_is_3375", {20'd0, res}, 32'd3375);

        // Start during busy is ignored.
        run_op(4'd5, 1);
        check("busy_start_125", {20'd0, res}, 32'd125);
        repeat (3) @(negedge clk);
        check("no_extra_op", {31'd0, busy}, 32'd0);

        // Reset on busy cycle 5 aborts with no result.
        x     = 4'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_abort_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_res", {20'd0, res}, 32'd0);
        check("abort_adder", {adder_a_in, adder_b_in}, 32'd0);
        last_res = '0;
        @(negedge clk);
        rst = 1'b1;
        run_op(4'd2, 0);
        check("after_abort_8", {20'd0, res}, 32'd8);

        // Back to back: second start on the cycle busy falls.
        run_op(4'd4, 0);
        check("b2b_64", {20'd0, res}, 32'd64);
        run_op(4'd6, 0);
        check("b2b_216", {20'd0, res}, 32'd216);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
